// File: rtl/mbgd_apb_master.sv
// mbgd_apb_master: APB master with a small command FIFO, serialising local read/write
// commands into SETUP/ACCESS phases for mbgd_regfile.
// Optional macro MBGD_APB_TIMEOUT_EN: bound ACCESS-phase waits to TIMEOUT_CYC cycles and
// report an expired transfer with rsp_err.
module mbgd_apb_master #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              apb_pclk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [ADDR_W-1:0] apb_paddress,
  output logic [DATA_W-1:0] apb_pwdata,
  input  logic [DATA_W-1:0] apb_prdata,
  input  logic              apb_pready,
  output logic              busy
);

  localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam int unsigned EntW = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q;
  logic [EntW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic              fifo_empty, fifo_full;
  logic              push, pop, xfer_done, timeout_hit;
  logic [EntW-1:0]   head;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                      (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign busy       = !fifo_empty || (state_q != StIdle);

  assign head       = fifo_mem[rd_ptr_q[IdxW-1:0]];
  assign head_write = head[EntW-1];
  assign head_addr  = head[EntW-2 -: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  assign xfer_done  = (state_q == StAccess) && (apb_pready || timeout_hit);
  assign pop        = !fifo_empty && ((state_q == StIdle) || xfer_done);

`ifdef MBGD_APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] tmo_cnt_q;
  logic            rsp_err_q;

  // Terminate on the edge that would count the TIMEOUT_CYC-th stalled ACCESS cycle.
  assign timeout_hit = (state_q == StAccess) && !apb_pready &&
                       (tmo_cnt_q == CntW'(TIMEOUT_CYC - 1));
  assign rsp_err     = rsp_err_q;

  // Wait counter: cleared whenever a new transfer enters SETUP, counts stalled ACCESS cycles.
  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
    end else if (pop) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == StAccess) && !apb_pready) begin
      tmo_cnt_q <= tmo_cnt_q + CntW'(1);
    end
  end

  // Error flag accompanies every response; cleared on successful reads.
  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) begin
      rsp_err_q <= 1'b0;
    end else if (xfer_done && (!apb_pwrite || timeout_hit)) begin
      rsp_err_q <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // Command storage; contents need no reset since the pointers define validity.
  always_ff @(posedge apb_pclk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[IdxW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  // FIFO pointers.
  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // APB phase sequencing with registered bus and response outputs.
  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      apb_psel     <= 1'b0;
      apb_penable  <= 1'b0;
      apb_pwrite   <= 1'b0;
      apb_paddress <= '0;
      apb_pwdata   <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q      <= StSetup;
            apb_psel     <= 1'b1;
            apb_penable  <= 1'b0;
            apb_pwrite   <= head_write;
            apb_paddress <= head_addr;
            if (head_write) apb_pwdata <= head_wdata;
          end
        end
        StSetup: begin
          state_q     <= StAccess;
          apb_penable <= 1'b1;
        end
        StAccess: begin
          if (xfer_done) begin
            if (!apb_pwrite || timeout_hit) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= timeout_hit ? '0 : apb_prdata;
            end
            if (!fifo_empty) begin
              state_q      <= StSetup;
              apb_penable  <= 1'b0;
              apb_pwrite   <= head_write;
              apb_paddress <= head_addr;
              if (head_write) apb_pwdata <= head_wdata;
            end else begin
              state_q     <= StIdle;
              apb_psel    <= 1'b0;
              apb_penable <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mbgd_apb_master.sv
// Self-checking bench for mbgd_apb_master: an in-bench APB slave memory with random wait
// states stands in for mbgd_regfile; expected transfers and responses come from an ordered
// command model (memory array plus queues).
module tb_mbgd_apb_master;

  logic       apb_pclk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       apb_psel, apb_penable, apb_pwrite;
  logic [7:0] apb_paddress, apb_pwdata;
  logic [7:0] apb_prdata = '0;
  logic       apb_pready = 1'b0;
  logic       busy;

  mbgd_apb_master #(
    .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .apb_pclk(apb_pclk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddress(apb_paddress), .apb_pwdata(apb_pwdata),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready), .busy(busy)
  );

  always #5 apb_pclk = ~apb_pclk;

  typedef struct {logic w; logic [7:0] a; logic [7:0] d;} xfer_t;
  typedef struct {logic [7:0] d; logic e;} rsp_t;

  int         ncmp = 0;
  int         nerr = 0;
  xfer_t      exp_xfer[$];
  rsp_t       exp_rsp[$];
  logic [7:0] model_mem [256];
  logic [7:0] slv_mem [256];

  bit         slv_stall = 1'b0;
  int         slv_fixed = -1;
  int         slv_left = 0;
  bit         slv_in_acc = 1'b0;
  int         acc_cycles = 0;
  int         last_acc_cycles = 0;
  logic [7:0] cap_a, cap_d;
  logic       cap_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push one command; on acceptance update the ordered model.
  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input bit tmo, output bit acc);
    @(negedge apb_pclk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    acc = cmd_ready;
    @(posedge apb_pclk);
    #1 cmd_valid = 1'b0;
    if (acc) begin
      if (tmo) begin
        exp_rsp.push_back('{8'h00, 1'b1});
      end else begin
        exp_xfer.push_back('{w, a, d});
        if (w) model_mem[a] = d;
        else   exp_rsp.push_back('{model_mem[a], 1'b0});
      end
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((busy || exp_rsp.size() != 0 || exp_xfer.size() != 0) && n < max) begin
      @(posedge apb_pclk);
      n++;
    end
    #1;
    if (n >= max) chk("drain_timeout_busy", 32'(busy), 32'd0);
  endtask

  // APB slave memory with per-transfer wait states; checks each completed transfer.
  initial begin
    xfer_t x;
    forever begin
      @(negedge apb_pclk);
      if (!resetn) begin
        apb_pready = 1'b0;
        slv_in_acc = 1'b0;
      end else if (apb_psel && apb_penable) begin
        if (!slv_in_acc) begin
          slv_in_acc = 1'b1; acc_cycles = 0;
          cap_a = apb_paddress; cap_w = apb_pwrite; cap_d = apb_pwdata;
        end else begin
          chk("acc_addr_stable", 32'(apb_paddress), 32'(cap_a));
          chk("acc_write_stable", 32'(apb_pwrite), 32'(cap_w));
          chk("acc_wdata_stable", 32'(apb_pwdata), 32'(cap_d));
        end
        acc_cycles++;
        if (!slv_stall && slv_left == 0) begin
          apb_pready = 1'b1;
          last_acc_cycles = acc_cycles;
          if (exp_xfer.size() == 0) begin
            chk("xfer_unexpected", 32'(apb_psel), 32'd0);
          end else begin
            x = exp_xfer.pop_front();
            chk("xfer_write", 32'(apb_pwrite), 32'(x.w));
            chk("xfer_addr", 32'(apb_paddress), 32'(x.a));
            if (x.w) chk("xfer_wdata", 32'(apb_pwdata), 32'(x.d));
          end
          if (apb_pwrite) begin
            slv_mem[apb_paddress] = apb_pwdata;
            apb_prdata = 8'($urandom);
          end else begin
            apb_prdata = slv_mem[apb_paddress];
          end
        end else begin
          apb_pready = 1'b0;
          apb_prdata = 8'($urandom);
          if (slv_left > 0) slv_left--;
        end
      end else begin
        slv_in_acc = 1'b0;
        apb_pready = 1'($urandom);
        apb_prdata = 8'($urandom);
        slv_left   = (slv_fixed >= 0) ? slv_fixed : int'($urandom_range(0, 3));
      end
    end
  end

  // Response monitor: every rsp_valid must match the next modelled response.
  initial begin
    rsp_t r;
    forever begin
      @(negedge apb_pclk);
      if (resetn && rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(r.d));
          chk("rsp_err", 32'(rsp_err), 32'(r.e));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int tries;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = '0;
      slv_mem[i]   = '0;
    end

    // Reset state.
    #12;
    chk("rst_psel", 32'(apb_psel), 32'd0);
    chk("rst_penable", 32'(apb_penable), 32'd0);
    chk("rst_pwrite", 32'(apb_pwrite), 32'd0);
    chk("rst_paddr", 32'(apb_paddress), 32'd0);
    chk("rst_pwdata", 32'(apb_pwdata), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge apb_pclk) resetn = 1'b1;
    repeat (2) @(posedge apb_pclk);

    // Back-to-back writes with zero wait states, exact phase timing.
    slv_fixed = 0;
    push(1'b1, 8'h00, 8'hEE, 1'b0, acc);
    chk("t1_n_psel", 32'(apb_psel), 32'd0);
    chk("t1_n_busy", 32'(busy), 32'd1);
    push(1'b1, 8'h01, 8'hCC, 1'b0, acc);
    chk("t1_n1_bus", 32'({apb_psel, apb_penable, apb_pwrite, apb_paddress, apb_pwdata}),
        32'({1'b1, 1'b0, 1'b1, 8'h00, 8'hEE}));
    @(posedge apb_pclk); #1;
    chk("t1_n2_bus", 32'({apb_psel, apb_penable, apb_paddress}), 32'({1'b1, 1'b1, 8'h00}));
    @(posedge apb_pclk); #1;
    chk("t1_n3_bus", 32'({apb_psel, apb_penable, apb_pwrite, apb_paddress, apb_pwdata}),
        32'({1'b1, 1'b0, 1'b1, 8'h01, 8'hCC}));
    chk("t1_n3_rsp", 32'(rsp_valid), 32'd0);
    @(posedge apb_pclk); #1;
    chk("t1_n4_bus", 32'({apb_psel, apb_penable}), 32'({1'b1, 1'b1}));
    @(posedge apb_pclk); #1;
    chk("t1_n5_bus", 32'({apb_psel, apb_penable, rsp_valid}), 32'd0);
    drain(50);

    // Reads back with latency N+3 and pwdata held.
    push(1'b0, 8'h00, 8'h55, 1'b0, acc);
    @(posedge apb_pclk); #1;
    chk("t2_n1_bus", 32'({apb_psel, apb_penable, apb_pwrite, apb_paddress, apb_pwdata}),
        32'({1'b1, 1'b0, 1'b0, 8'h00, 8'hCC}));
    @(posedge apb_pclk); #1;
    chk("t2_n2_penable", 32'(apb_penable), 32'd1);
    chk("t2_n2_rsp", 32'(rsp_valid), 32'd0);
    @(posedge apb_pclk); #1;
    chk("t2_n3_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({1'b1, 1'b0, 8'hEE}));
    @(posedge apb_pclk); #1;
    chk("t2_n4_pulse", 32'(rsp_valid), 32'd0);
    chk("t2_n4_hold", 32'(rsp_rdata), 32'hEE);
    push(1'b0, 8'h01, 8'h00, 1'b0, acc);
    drain(50);
    chk("t2_rd01", 32'(rsp_rdata), 32'hCC);

    // FIFO fills while the slave stalls; sixth command refused.
    slv_fixed = -1;
    slv_stall = 1'b1;
    push(1'b1, 8'h14, 8'hCC, 1'b0, acc);
    push(1'b1, 8'h18, 8'h39, 1'b0, acc);
    push(1'b0, 8'h14, 8'h00, 1'b0, acc);
    push(1'b0, 8'h18, 8'h00, 1'b0, acc);
    chk("t3_ready_before_full", 32'(cmd_ready), 32'd1);
    push(1'b1, 8'h1C, 8'h5A, 1'b0, acc);
    chk("t3_push5_acc", 32'(acc), 32'd1);
    chk("t3_full_ready", 32'(cmd_ready), 32'd0);
    push(1'b0, 8'h1C, 8'h00, 1'b0, acc);
    chk("t3_push6_refused", 32'(acc), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    slv_stall = 1'b0;
    drain(200);
    chk("t3_ready_after", 32'(cmd_ready), 32'd1);

    // Three wait states: four stable ACCESS cycles.
    slv_fixed = 3;
    push(1'b0, 8'h14, 8'h00, 1'b0, acc);
    drain(50);
    chk("t4_acc_cycles", 32'(last_acc_cycles), 32'd4);
    chk("t4_rdata_hold", 32'(rsp_rdata), 32'hCC);
    slv_fixed = -1;

    // Randomised traffic over a small address window.
    for (int k = 0; k < 40; k++) begin
      logic       w;
      logic [7:0] a, d;
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 50) begin
        push(w, a, d, 1'b0, acc);
        tries++;
      end
      if (!acc) chk("rand_push_stuck", 32'(cmd_ready), 32'd1);
      repeat ($urandom_range(0, 2)) @(posedge apb_pclk);
    end
    drain(500);

    // Reset during ACCESS of a queued read discards everything.
    slv_stall = 1'b1;
    push(1'b0, 8'h05, 8'h00, 1'b0, acc);
    push(1'b0, 8'h06, 8'h00, 1'b0, acc);
    tries = 0;
    while (!apb_penable && tries < 20) begin
      @(negedge apb_pclk);
      tries++;
    end
    chk("t5_in_access", 32'(apb_penable), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_bus", 32'({apb_psel, apb_penable, apb_pwrite, apb_paddress, apb_pwdata}),
        32'd0);
    chk("t5_async_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_ready", 32'(cmd_ready), 32'd1);
    exp_xfer.delete();
    exp_rsp.delete();
    slv_stall = 1'b0;
    repeat (2) @(negedge apb_pclk);
    resetn = 1'b1;
    repeat (10) @(posedge apb_pclk);
    #1;
    chk("t5_post_busy", 32'(busy), 32'd0);
    chk("t5_post_psel", 32'(apb_psel), 32'd0);
    chk("t5_post_ready", 32'(cmd_ready), 32'd1);

    // Stalled read: timeout response, or an indefinite stall without the feature.
    slv_stall = 1'b1;
`ifdef MBGD_APB_TIMEOUT_EN
    push(1'b0, 8'h20, 8'h00, 1'b1, acc);
    repeat (17) @(posedge apb_pclk);
    #1;
    chk("t6_before_timeout", 32'(rsp_valid), 32'd0);
    chk("t6_still_access", 32'(apb_penable), 32'd1);
    @(posedge apb_pclk); #1;
    chk("t6_timeout_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({1'b1, 1'b1, 8'h00}));
    chk("t6_idle", 32'({busy, apb_psel, apb_penable}), 32'd0);
    slv_stall = 1'b0;
    drain(50);
`else
    push(1'b0, 8'h20, 8'h00, 1'b0, acc);
    repeat (30) @(posedge apb_pclk);
    #1;
    chk("t6_stall_busy", 32'(busy), 32'd1);
    chk("t6_stall_bus", 32'({apb_psel, apb_penable}), 32'({1'b1, 1'b1}));
    chk("t6_stall_err", 32'(rsp_err), 32'd0);
    slv_stall = 1'b0;
    drain(50);
    chk("t6_rd20", 32'(rsp_rdata), 32'h00);
`endif

    repeat (3) @(posedge apb_pclk);
    #1;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_rsp_queue", 32'(exp_rsp.size()), 32'd0);
    chk("end_xfer_queue", 32'(exp_xfer.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mbgd_apb_master.md
Name: mbgd_apb_master

Overview:
Hardware APB master that issues register transactions to mbgd_regfile. It sits directly upstream of the regfile's APB slave port and replaces the bench-level cpu_write/cpu_read tasks with synthesizable logic. A local requester pushes commands (read or write, address, data) into a small command FIFO. The block serialises them into APB SETUP/ACCESS phases, honours pready wait states, and returns read data on a one-cycle response strobe.

Parameters:
ADDR_W, 8, APB address width
DATA_W, 8, APB data width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT_CYC, 16, ACCESS-phase wait limit; used only when the optional feature is compiled in

Ports:
apb_pclk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command (= !full)
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target register address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse: read completed, or any timeout
rsp_rdata  out  DATA_W  captured read data
rsp_err  out  1  transfer ended by timeout (qualified by rsp_valid)
apb_psel  out  1  APB select
apb_penable  out  1  APB enable
apb_pwrite  out  1  APB direction
apb_paddress  out  ADDR_W  APB address
apb_pwdata  out  DATA_W  APB write data
apb_prdata  in  DATA_W  APB read data from regfile
apb_pready  in  1  APB slave ready
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Clocking and reset: single clock, apb_pclk. Reset is asynchronous and active-low on resetn.
- Reset values: psel, penable, pwrite, paddress, pwdata, rsp_valid, rsp_rdata and rsp_err are 0. FIFO is empty, so cmd_ready = 1 and busy = 0. FSM is in IDLE.
- Reset asserted mid-transfer aborts the transfer immediately, with no response and FIFO contents discarded.
- FIFO push: occurs on a rising edge with cmd_valid & cmd_ready. Full means FIFO_DEPTH entries are held. When full, cmd_ready = 0 and a same-cycle pop does not enable a push.
- FIFO: read and write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full and empty are decoded from the MSB and pointer equality.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE -> SETUP when the FIFO is non-empty. On that edge, pop the head entry and load paddress, pwdata and pwrite. Drive psel = 1, penable = 0.
- SETUP -> ACCESS unconditionally on the next edge. Drive penable = 1.
- ACCESS with pready = 0: hold the state. psel, penable, paddress, pwrite and pwdata stay stable.
- ACCESS with pready = 1: the transfer completes.
  - On a read, capture prdata into rsp_rdata and pulse rsp_valid for 1 cycle with rsp_err = 0.
  - On a write, no response is produced.
  - If the FIFO is non-empty, go to SETUP: pop the next entry, psel stays 1, penable = 0 (back-to-back transfer).
  - Otherwise go to IDLE with psel = penable = 0.
- Latency: a command pushed at edge N into an empty FIFO while in IDLE has psel = 1 after edge N+1 and penable = 1 after edge N+2. With zero wait states, read data appears on rsp_rdata with rsp_valid after edge N+3.
- Throughput: minimum 2 cycles per transfer.
- rsp_rdata holds its last value between responses. pwdata holds its last value during reads.

Optional Feature:
Macro MBGD_APB_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS. It clears on entry to SETUP and increments each ACCESS cycle with pready = 0.
  - When the count reaches TIMEOUT_CYC, the transfer terminates as if pready had been seen.
  - rsp_valid pulses with rsp_err = 1 and rsp_rdata = 0, for both reads and writes.
- Not defined: ACCESS waits indefinitely, rsp_err is tied to 0, and no counter logic exists.

Test Plan:
1. Reset; push write 0x00<-0xEE, then write 0x01<-0xCC, with pready tied to 1 -> two APB writes with correct SETUP/ACCESS timing, psel held high across both (back-to-back), no rsp_valid.
2. Push read 0x00 after test 1 against mbgd_regfile -> rsp_valid for 1 cycle with rsp_rdata = 0xEE; then read 0x01 -> 0xCC.
3. Push 5 commands with FIFO_DEPTH = 4 while pready = 0 -> cmd_ready drops after the 4th push accepted into the FIFO (first already popped into SETUP). Release pready and all transfers complete in order (write 0x14<-0xCC, write 0x18<-0x39, ...).
4. Read 0x14 with pready low for 3 ACCESS cycles -> paddress, pwrite and penable stable for 4 ACCESS cycles; rsp_rdata = 0xCC one cycle after pready.
5. Assert resetn low during ACCESS of a queued read -> all outputs 0 asynchronously, no rsp_valid, busy = 0, cmd_ready = 1 after release.
6. With MBGD_APB_TIMEOUT_EN and TIMEOUT_CYC = 16, pready held 0 on a read of 0x20 -> after 16 ACCESS cycles rsp_valid = 1, rsp_err = 1, rsp_rdata = 0x00, FSM returns to IDLE. Without the macro, the same stimulus stalls with busy = 1.
